fx3_transfer_scheduler: RTL and testbench
=========================================

# fx3_transfer_scheduler

Sequences sample-buffer-to-FX3 packet transfers for the capture path. It sits between the sample FIFO and the FX3 GPIF interface. When capture is enabled, it flushes the FIFO, waits until a full packet is buffered, and advertises availability to the FX3. It then streams exactly one packet of words per GPIF read request. It also keeps a packet count and a sticky overflow flag for the host.

## Interface
- PACKET_WORDS, 8192: words per FX3 packet; must be ≥ 2.
- LEVEL_W, 16: width of FIFO fill-level input; 2^LEVEL_W > PACKET_WORDS.
- FLUSH_CYCLES, 4: cycles fifoClear is held on capture start; ≥ 1.

- inclk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- collectEnable  in  1  host capture request, level-sensitive.
- fifoLevel  in  LEVEL_W  words currently held in sample FIFO.
- fifoFull  in  1  sample FIFO full (write dropped this cycle).
- readData  in  1  FX3 GPIF read strobe; high = FX3 accepting a word.
- dataAvailable  out  1  a full packet is buffered and awaiting request.
- fifoRead  out  1  pop one word from sample FIFO this cycle.
- fifoClear  out  1  flush sample FIFO.
- packetActive  out  1  packet transfer in progress.
- packetCount  out  16  completed packets since capture start; wraps at 65535→0.
- overflow  out  1  sticky: FIFO filled during capture.

## Operation
- readData is registered into readDataReg every cycle; only readDataReg is used internally. reset clears readDataReg.
- States: IDLE, FLUSH, WAIT_LEVEL, WAIT_REQUEST, STREAM. reset → IDLE.
- IDLE: all outputs low except packetCount/overflow (hold). collectEnable=1 → FLUSH.
- FLUSH: fifoClear=1. Flush counter runs 0..FLUSH_CYCLES-1. Entering FLUSH clears packetCount and overflow. After FLUSH_CYCLES cycles → WAIT_LEVEL. collectEnable is ignored in FLUSH.
- WAIT_LEVEL: if collectEnable=0 → IDLE; else if fifoLevel ≥ PACKET_WORDS → WAIT_REQUEST.
- WAIT_REQUEST: dataAvailable=1. collectEnable=0 → IDLE, and this takes priority. Else readDataReg=1 → STREAM.
- STREAM: packetActive=1; fifoRead = readDataReg.
  - Word counter (width ceil(log2(PACKET_WORDS))) starts at 0 on entry and increments on each fifoRead.
  - fifoRead with counter = PACKET_WORDS-1 completes the packet. packetCount increments and the counter clears. Next state is WAIT_LEVEL if collectEnable=1, otherwise IDLE.
  - readDataReg=0 stalls: no pop, counter holds, state holds.
  - collectEnable=0 mid-packet does not abort; the packet always completes.
- overflow: set when fifoFull=1 in WAIT_LEVEL, WAIT_REQUEST or STREAM. Cleared only by reset or FLUSH entry. Streaming continues after overflow.
- Exactly PACKET_WORDS fifoRead pulses per completed packet; never more.

## Timing
- Reset values:
  - state IDLE; counters 0.
  - dataAvailable, fifoRead, fifoClear, packetActive, overflow = 0.
  - packetCount = 0.
- dataAvailable, fifoClear, packetActive are Moore outputs decoded from the state register. fifoRead is the state register ANDed with readDataReg, with no combinational path from any input pin.
- collectEnable rising at edge N: FLUSH from N+1, fifoClear high N+1..N+FLUSH_CYCLES, WAIT_LEVEL at N+FLUSH_CYCLES+1.
- Level check: fifoLevel ≥ PACKET_WORDS sampled at edge M → dataAvailable high from M+1.
- Request latency: readData high at edge K (in WAIT_REQUEST) → readDataReg high at K+1 → STREAM at K+2 → first fifoRead in K+2 cycle if readData still high at K+1.
- Last pop at cycle L: packetCount updated and state leaves STREAM at edge L+1. Earliest next dataAvailable at L+2.
- reset mid-STREAM: next cycle IDLE, all outputs at reset values, partial packet discarded.
- Simultaneous fifoFull and last pop: overflow sets and packet completes in the same edge.

## Test plan
- Reset with all inputs high for 3 cycles → all outputs 0, state IDLE; release with collectEnable=0 → outputs stay 0.
- collectEnable=1, PACKET_WORDS=8192, FLUSH_CYCLES=4, fifoLevel=8192, readData held high → fifoClear exactly 4 cycles, dataAvailable then 8192 consecutive fifoRead pulses, packetCount=1, dataAvailable again 2 cycles later.
- Same, but readData low for 10 cycles after word 100 → fifoRead low for exactly those 10 cycles (offset by 1), total pops still 8192.
- fifoLevel=8191 held → dataAvailable never asserts; step to 8192 → dataAvailable next cycle.
- collectEnable dropped at word 4000 → packet completes (8192 pops), packetCount=1, state IDLE, no dataAvailable; drop in WAIT_REQUEST → IDLE next cycle.
- fifoFull pulsed 1 cycle in WAIT_LEVEL → overflow=1 sticky through 3 packets; collectEnable toggled 0→1 → overflow and packetCount cleared at FLUSH entry; packetCount forced across 65535 → wraps to 0.

Source files
------------

// File: rtl/fx3_transfer_scheduler.sv
// Capture-path transfer sequencer between the sample FIFO and the FX3 GPIF port.
// Flushes on capture start, advertises full packets, streams one packet per request.
module fx3_transfer_scheduler #(
    parameter int PACKET_WORDS = 8192,
    parameter int LEVEL_W      = 16,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic               inclk,
    input  logic               reset,
    input  logic               collectEnable,
    input  logic [LEVEL_W-1:0] fifoLevel,
    input  logic               fifoFull,
    input  logic               readData,
    output logic               dataAvailable,
    output logic               fifoRead,
    output logic               fifoClear,
    output logic               packetActive,
    output logic [15:0]        packetCount,
    output logic               overflow
);

    localparam int CW = $clog2(PACKET_WORDS);
    localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0]      LAST_WORD  = CW'(PACKET_WORDS - 1);
    localparam logic [FW-1:0]      LAST_FLUSH = FW'(FLUSH_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] PKT_LEVEL  = LEVEL_W'(PACKET_WORDS);

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        FLUSH        = 3'd1,
        WAIT_LEVEL   = 3'd2,
        WAIT_REQUEST = 3'd3,
        STREAM       = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic          read_data_q;
    logic [CW-1:0] word_cnt_q, word_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic [15:0]   packet_count_q, packet_count_d;
    logic          overflow_q, overflow_d;
    logic          pop_s;

    // A pop depends only on registered state, never on an input pin directly.
    assign pop_s = (state_q == STREAM) && read_data_q;

    // State and counter registers with synchronous reset.
    always_ff @(posedge inclk) begin
        if (reset) begin
            state_q        <= IDLE;
            read_data_q    <= 1'b0;
            word_cnt_q     <= '0;
            flush_cnt_q    <= '0;
            packet_count_q <= 16'd0;
            overflow_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            read_data_q    <= readData;
            word_cnt_q     <= word_cnt_d;
            flush_cnt_q    <= flush_cnt_d;
            packet_count_q <= packet_count_d;
            overflow_q     <= overflow_d;
        end
    end

    // Next-state, counter and sticky-flag logic.
    always_comb begin
        state_d        = state_q;
        word_cnt_d     = word_cnt_q;
        flush_cnt_d    = flush_cnt_q;
        packet_count_d = packet_count_q;
        overflow_d     = overflow_q;

        if (fifoFull && (state_q == WAIT_LEVEL || state_q == WAIT_REQUEST || state_q == STREAM)) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end

        case (state_q)
            IDLE: begin
                if (collectEnable) begin
                    state_d        = FLUSH;
                    flush_cnt_d    = '0;
                    word_cnt_d     = '0;
                    packet_count_d = 16'd0;
                    overflow_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == LAST_FLUSH) begin
                    flush_cnt_d = '0;
                    state_d     = WAIT_LEVEL;
                end else begin
                    flush_cnt_d = flush_cnt_q + FW'(1);
                end
            end
            WAIT_LEVEL: begin
                if (!collectEnable) begin
                    state_d = IDLE;
                end else if (fifoLevel >= PKT_LEVEL) begin
                    state_d = WAIT_REQUEST;
                end else begin
                    state_d = WAIT_LEVEL;
                end
            end
            WAIT_REQUEST: begin
                word_cnt_d = '0;
                if (!collectEnable) begin
                    state_d = IDLE;
                end else if (read_data_q) begin
                    state_d = STREAM;
                end else begin
                    state_d = WAIT_REQUEST;
                end
            end
            STREAM: begin
                // A dropped collectEnable only decides where to go after the packet.
                if (pop_s) begin
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d     = '0;
                        packet_count_d = packet_count_q + 16'd1;
                        state_d        = collectEnable ? WAIT_LEVEL : IDLE;
                    end else begin
                        word_cnt_d = word_cnt_q + CW'(1);
                    end
                end else begin
                    word_cnt_d = word_cnt_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dataAvailable = (state_q == WAIT_REQUEST);
    assign fifoClear     = (state_q == FLUSH);
    assign packetActive  = (state_q == STREAM);
    assign fifoRead      = pop_s;
    assign packetCount   = packet_count_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_fx3_transfer_scheduler.sv
// Directed self-checking bench for fx3_transfer_scheduler at PACKET_WORDS=8192, FLUSH_CYCLES=4.
module tb_fx3_transfer_scheduler;

    logic        inclk = 1'b0;
    logic        reset = 1'b0;
    logic        collectEnable = 1'b0;
    logic [15:0] fifoLevel = 16'd0;
    logic        fifoFull = 1'b0;
    logic        readData = 1'b0;
    logic        dataAvailable, fifoRead, fifoClear, packetActive, overflow;
    logic [15:0] packetCount;

    int n_checks = 0;
    int n_fail   = 0;

    fx3_transfer_scheduler #(.PACKET_WORDS(8192), .LEVEL_W(16), .FLUSH_CYCLES(4)) dut (
        .inclk(inclk), .reset(reset), .collectEnable(collectEnable),
        .fifoLevel(fifoLevel), .fifoFull(fifoFull), .readData(readData),
        .dataAvailable(dataAvailable), .fifoRead(fifoRead), .fifoClear(fifoClear),
        .packetActive(packetActive), .packetCount(packetCount), .overflow(overflow)
    );

    always #5 inclk = ~inclk;

    task automatic do_reset();
        @(negedge inclk);
        reset = 1'b1; collectEnable = 1'b0; fifoLevel = 16'd0; fifoFull = 1'b0; readData = 1'b0;
        repeat (2) @(negedge inclk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge inclk);
        reset = 1'b1; collectEnable = 1'b1; fifoLevel = 16'hFFFF; fifoFull = 1'b1; readData = 1'b1;
        repeat (3) @(negedge inclk);
        n_checks++;
        if ({dataAvailable, fifoRead, fifoClear, packetActive, overflow} !== 5'b0 || packetCount !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_hold: outs=%b count=%0d expected 00000/0",
                     {dataAvailable, fifoRead, fifoClear, packetActive, overflow}, packetCount);
        end
        reset = 1'b0; collectEnable = 1'b0; fifoFull = 1'b0; readData = 1'b0;
        repeat (3) @(negedge inclk);
        n_checks++;
        if ({dataAvailable, fifoRead, fifoClear, packetActive, overflow} !== 5'b0 || packetCount !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_release: outs=%b count=%0d expected 00000/0",
                     {dataAvailable, fifoRead, fifoClear, packetActive, overflow}, packetCount);
        end
    endtask

    task automatic test_full_packet();
        int clears = 0;
        int pops = 0;
        int first = -1;
        int last = -1;
        int cyc = 0;
        do_reset();
        fifoLevel = 16'd8192; readData = 1'b1; collectEnable = 1'b1;
        while (dataAvailable !== 1'b1 && cyc < 40) begin
            @(negedge inclk);
            cyc++;
            if (fifoClear === 1'b1) clears++;
        end
        n_checks++;
        if (clears !== 4 || dataAvailable !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_len: clears=%0d avail=%b expected 4/1", clears, dataAvailable);
        end
        cyc = 0;
        while (packetCount !== 16'd1 && cyc < 9000) begin
            @(negedge inclk);
            cyc++;
            if (fifoRead === 1'b1) begin
                pops++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        n_checks++;
        if (pops !== 8192 || (last - first + 1) !== 8192 || packetCount !== 16'd1) begin
            n_fail++;
            $display("FAIL full_packet: pops=%0d span=%0d count=%0d expected 8192/8192/1",
                     pops, last - first + 1, packetCount);
        end
        n_checks++;
        if (dataAvailable !== 1'b0) begin
            n_fail++;
            $display("FAIL avail_gap: avail=%b expected 0", dataAvailable);
        end
        @(negedge inclk);
        n_checks++;
        if (dataAvailable !== 1'b1) begin
            n_fail++;
            $display("FAIL avail_again: avail=%b expected 1", dataAvailable);
        end
    endtask

    task automatic test_stall();
        int pops = 0;
        int gaps = 0;
        int stall_left = 0;
        int cyc = 0;
        bit stalled = 1'b0;
        do_reset();
        fifoLevel = 16'd8192; readData = 1'b1; collectEnable = 1'b1;
        while (packetCount !== 16'd1 && cyc < 9000) begin
            @(negedge inclk);
            cyc++;
            if (fifoRead === 1'b1) pops++;
            if (packetActive === 1'b1 && fifoRead !== 1'b1) gaps++;
            if (pops == 100 && !stalled) begin
                stalled = 1'b1;
                readData = 1'b0;
                stall_left = 10;
            end else if (stall_left > 0) begin
                stall_left--;
                if (stall_left == 0) readData = 1'b1;
            end
        end
        n_checks++;
        if (gaps !== 10) begin
            n_fail++;
            $display("FAIL stall_gap: gaps=%0d expected 10", gaps);
        end
        n_checks++;
        if (pops !== 8192 || packetCount !== 16'd1) begin
            n_fail++;
            $display("FAIL stall_pops: pops=%0d count=%0d expected 8192/1", pops, packetCount);
        end
    endtask

    task automatic test_level();
        int seen = 0;
        do_reset();
        fifoLevel = 16'd8191; readData = 1'b0; collectEnable = 1'b1;
        repeat (20) begin
            @(negedge inclk);
            if (dataAvailable === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL level_below: avail_cycles=%0d expected 0", seen);
        end
        fifoLevel = 16'd8192;
        @(negedge inclk);
        n_checks++;
        if (dataAvailable !== 1'b1) begin
            n_fail++;
            $display("FAIL level_reached: avail=%b expected 1", dataAvailable);
        end
        collectEnable = 1'b0;
        @(negedge inclk);
        n_checks++;
        if ({dataAvailable, packetActive, fifoRead, fifoClear} !== 4'b0) begin
            n_fail++;
            $display("FAIL drop_in_request: outs=%b expected 0000",
                     {dataAvailable, packetActive, fifoRead, fifoClear});
        end
        collectEnable = 1'b1;
        @(negedge inclk);
        n_checks++;
        if (fifoClear !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_from_idle: fifoClear=%b expected 1", fifoClear);
        end
    endtask

    task automatic test_drop_mid_packet();
        int pops = 0;
        int cyc = 0;
        int bad = 0;
        do_reset();
        fifoLevel = 16'd8192; readData = 1'b1; collectEnable = 1'b1;
        while (packetCount !== 16'd1 && cyc < 9000) begin
            @(negedge inclk);
            cyc++;
            if (fifoRead === 1'b1) pops++;
            if (pops == 4000) collectEnable = 1'b0;
        end
        n_checks++;
        if (pops !== 8192 || packetCount !== 16'd1) begin
            n_fail++;
            $display("FAIL drop_mid_pops: pops=%0d count=%0d expected 8192/1", pops, packetCount);
        end
        repeat (5) begin
            if ({dataAvailable, packetActive, fifoRead, fifoClear} !== 4'b0) bad++;
            @(negedge inclk);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL drop_mid_idle: active_cycles=%0d expected 0", bad);
        end
    endtask

    task automatic test_overflow();
        int pops = 0;
        int cyc = 0;
        int lost = 0;
        do_reset();
        fifoLevel = 16'd0; readData = 1'b1; collectEnable = 1'b1;
        repeat (6) @(negedge inclk);
        n_checks++;
        if (fifoClear !== 1'b0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_pre: clear=%b ovf=%b expected 0/0", fifoClear, overflow);
        end
        fifoFull = 1'b1;
        @(negedge inclk);
        fifoFull = 1'b0;
        @(negedge inclk);
        n_checks++;
        if (overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_set: ovf=%b expected 1", overflow);
        end
        fifoLevel = 16'd8192;
        while (packetCount !== 16'd3 && cyc < 30000) begin
            @(negedge inclk);
            cyc++;
            if (fifoRead === 1'b1) pops++;
            if (overflow !== 1'b1) lost++;
        end
        collectEnable = 1'b0;
        n_checks++;
        if (pops !== 3 * 8192 || lost !== 0 || packetCount !== 16'd3) begin
            n_fail++;
            $display("FAIL ovf_sticky: pops=%0d ovf_low=%0d count=%0d expected 24576/0/3",
                     pops, lost, packetCount);
        end
        @(negedge inclk);
        collectEnable = 1'b1;
        @(negedge inclk);
        n_checks++;
        if (fifoClear !== 1'b1 || overflow !== 1'b0 || packetCount !== 16'd0) begin
            n_fail++;
            $display("FAIL ovf_clear: clear=%b ovf=%b count=%0d expected 1/0/0",
                     fifoClear, overflow, packetCount);
        end
    endtask

    initial begin
        test_reset();
        test_full_packet();
        test_stall();
        test_level();
        test_drop_mid_packet();
        test_overflow();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
